wb_reg_file: RTL and testbench

Writeback stage plus architectural register file, directly downstream of the MEM/WB pipeline segment. Each cycle it selects the writeback source, either load data or the ALU/link result. It then writes that value into the 32-entry register file under per-byte enables. Two read ports serve the ID stage, with same-cycle write-to-read bypass, so the decoder never sees a stale value from an instruction completing writeback.

---
 rtl/wb_reg_file_pkg.sv | 31 +++
 rtl/wb_byte_merge.sv | 23 ++
 rtl/wb_reg_file.sv | 106 ++++++++++
 tb/tb_wb_reg_file.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_reg_file_pkg
//  Description : Shared writeback/register-file constants and the byte-merge
//                helper used by both the write path and the read bypass.
//  Revision    : 1.0  initial release
// ============================================================================
package wb_reg_file_pkg;

   localparam int REG_ZERO  = 0;   // index of the hardwired-zero register
   localparam int BYTE_EN_W = 4;   // one enable bit per byte lane
   localparam int WORD_W    = 32;  // architectural register width

   // Take new_w bytes where the lane enable is set, old_w bytes elsewhere.
   function automatic logic [WORD_W-1:0] byte_merge(
      input logic [WORD_W-1:0]    old_w,
      input logic [WORD_W-1:0]    new_w,
      input logic [BYTE_EN_W-1:0] en
   );
      logic [WORD_W-1:0] w_merged;
      w_merged = old_w;
      for (int i = 0; i < BYTE_EN_W; i++) begin
         if (en[i]) begin
            w_merged[8*i +: 8] = new_w[8*i +: 8];
         end
      end
      return w_merged;
   endfunction

endpackage : wb_reg_file_pkg
`default_nettype wire

// File: rtl/wb_byte_merge.sv
`default_nettype none
// ============================================================================
//  Module      : wb_byte_merge
//  Description : Combinational per-byte merge of a new word over an old word.
//  Ports       : i_old    - stored word
//                i_new    - incoming writeback word
//                i_en     - per-byte lane enables (bit i -> bits [8i+7:8i])
//                o_merged - merged result
//  Revision    : 1.0  initial release
// ============================================================================
module wb_byte_merge
   import wb_reg_file_pkg::*;
(
   input  logic [WORD_W-1:0]    i_old,
   input  logic [WORD_W-1:0]    i_new,
   input  logic [BYTE_EN_W-1:0] i_en,
   output logic [WORD_W-1:0]    o_merged
);

   assign o_merged = byte_merge(i_old, i_new, i_en);

endmodule : wb_byte_merge
`default_nettype wire

// File: rtl/wb_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : wb_reg_file
//  Description : Writeback source select plus 2**ADDR_W-entry register file
//                with per-byte writes and two bypassed combinational read
//                ports for the ID stage.
//  Ports       : Clk, Reset          - clock, async active-high reset
//                MemData, WBData     - load / non-load writeback sources
//                MemWBSrc            - 1 selects MemData
//                Rd_Write_Byte_en    - per-byte write enables
//                Rd                  - destination register
//                Rs_addr, Rt_addr    - read port addresses
//                Rs_data, Rt_data    - bypassed read data
//                WB_fwd_data/_valid  - writeback value for EX forwarding
//  Revision    : 1.0  initial release
// ============================================================================
module wb_reg_file
   import wb_reg_file_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic [WORD_W-1:0]    MemData,
   input  logic [WORD_W-1:0]    WBData,
   input  logic                 MemWBSrc,
   input  logic [BYTE_EN_W-1:0] Rd_Write_Byte_en,
   input  logic [ADDR_W-1:0]    Rd,
   input  logic [ADDR_W-1:0]    Rs_addr,
   input  logic [ADDR_W-1:0]    Rt_addr,
   output logic [WORD_W-1:0]    Rs_data,
   output logic [WORD_W-1:0]    Rt_data,
   output logic [WORD_W-1:0]    WB_fwd_data,
   output logic                 WB_fwd_valid
);

   localparam int NREG = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

   logic [WORD_W-1:0]    r_regs [NREG];

   logic [WORD_W-1:0]    w_wb_val;
   logic                 w_we;
   logic                 w_rd_zero;
   logic                 w_rs_zero;
   logic                 w_rt_zero;
   logic [BYTE_EN_W-1:0] w_rs_en;
   logic [BYTE_EN_W-1:0] w_rt_en;
   logic [WORD_W-1:0]    w_wr_word;
   logic [WORD_W-1:0]    w_rs_merged;
   logic [WORD_W-1:0]    w_rt_merged;

   assign w_wb_val  = MemWBSrc ? MemData : WBData;

   assign w_rd_zero = ZERO_REG && (Rd      == ZERO_IDX);
   assign w_rs_zero = ZERO_REG && (Rs_addr == ZERO_IDX);
   assign w_rt_zero = ZERO_REG && (Rt_addr == ZERO_IDX);

   // A real write: some lane enabled, not the hardwired-zero entry, not in reset.
   assign w_we = (Rd_Write_Byte_en != '0) && !w_rd_zero && !Reset;

   // A port only picks up the in-flight write when it targets Rd; otherwise
   // its merge degenerates to the stored word (all lanes disabled).
   assign w_rs_en = (w_we && (Rs_addr == Rd)) ? Rd_Write_Byte_en : '0;
   assign w_rt_en = (w_we && (Rt_addr == Rd)) ? Rd_Write_Byte_en : '0;

   wb_byte_merge u_wr_merge (
      .i_old    (r_regs[Rd]),
      .i_new    (w_wb_val),
      .i_en     (Rd_Write_Byte_en),
      .o_merged (w_wr_word)
   );

   wb_byte_merge u_rs_merge (
      .i_old    (r_regs[Rs_addr]),
      .i_new    (w_wb_val),
      .i_en     (w_rs_en),
      .o_merged (w_rs_merged)
   );

   wb_byte_merge u_rt_merge (
      .i_old    (r_regs[Rt_addr]),
      .i_new    (w_wb_val),
      .i_en     (w_rt_en),
      .o_merged (w_rt_merged)
   );

   // Flop array (not RAM) so the asynchronous reset can clear every entry.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_we) begin
         r_regs[Rd] <= w_wr_word;
      end
   end

   assign Rs_data      = (Reset || w_rs_zero) ? '0 : w_rs_merged;
   assign Rt_data      = (Reset || w_rt_zero) ? '0 : w_rt_merged;
   assign WB_fwd_data  = Reset ? '0 : w_wb_val;
   assign WB_fwd_valid = w_we;

endmodule : wb_reg_file
`default_nettype wire

// File: tb/tb_wb_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_reg_file
//  Description : Self-checking bench for wb_reg_file: directed scenarios with
//                literal expectations plus randomized traffic compared every
//                cycle against a word-array reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_reg_file;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] MemData = '0;
   logic [31:0] WBData = '0;
   logic        MemWBSrc = 1'b0;
   logic [3:0]  Rd_Write_Byte_en = '0;
   logic [4:0]  Rd = '0;
   logic [4:0]  Rs_addr = '0;
   logic [4:0]  Rt_addr = '0;
   logic [31:0] Rs_data;
   logic [31:0] Rt_data;
   logic [31:0] WB_fwd_data;
   logic        WB_fwd_valid;

   int checks = 0;
   int errors = 0;

   logic [31:0] model [32];

   wb_reg_file #(.ADDR_W(5), .ZERO_REG(1'b1)) dut (
      .Clk              (Clk),
      .Reset            (Reset),
      .MemData          (MemData),
      .WBData           (WBData),
      .MemWBSrc         (MemWBSrc),
      .Rd_Write_Byte_en (Rd_Write_Byte_en),
      .Rd               (Rd),
      .Rs_addr          (Rs_addr),
      .Rt_addr          (Rt_addr),
      .Rs_data          (Rs_data),
      .Rt_data          (Rt_data),
      .WB_fwd_data      (WB_fwd_data),
      .WB_fwd_valid     (WB_fwd_valid)
   );

   always #5 Clk = ~Clk;

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_wb();
      return MemWBSrc ? MemData : WBData;
   endfunction

   function automatic logic m_write();
      return (Rd_Write_Byte_en != 4'b0) && (Rd != 5'd0) && !Reset;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      logic [31:0] v;
      logic [31:0] w;
      if (Reset || a == 5'd0) return 32'h0;
      v = model[a];
      w = m_wb();
      if (m_write() && a == Rd) begin
         for (int b = 0; b < 4; b++)
            if (Rd_Write_Byte_en[b]) v[8*b +: 8] = w[8*b +: 8];
      end
      return v;
   endfunction

   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int k = 0; k < 32; k++) model[k] = 32'h0;
      end else if (m_write()) begin
         model[Rd] = m_read(Rd);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Every-cycle comparison against the model, sampled mid-cycle.
   always @(negedge Clk) begin
      check("cyc_rs",    Rs_data,      m_read(Rs_addr));
      check("cyc_rt",    Rt_data,      m_read(Rt_addr));
      check("cyc_fwd",   WB_fwd_data,  Reset ? 32'h0 : m_wb());
      check("cyc_valid", {31'h0, WB_fwd_valid}, {31'h0, m_write()});
   end

   // Inputs change shortly after the active edge.
   task automatic drive(input logic src, input logic [31:0] md, input logic [31:0] wd,
                        input logic [3:0] en, input logic [4:0] rd,
                        input logic [4:0] rs, input logic [4:0] rt);
      @(posedge Clk);
      #2;
      MemWBSrc = src; MemData = md; WBData = wd;
      Rd_Write_Byte_en = en; Rd = rd; Rs_addr = rs; Rt_addr = rt;
   endtask

   initial begin
      // ---- reset, all entries read zero ----
      repeat (2) @(posedge Clk);
      #2 Reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         Rs_addr = 5'(i);
         Rt_addr = 5'(31 - i);
         #1;
         check("rst_rs", Rs_data, 32'h0);
         check("rst_rt", Rt_data, 32'h0);
      end

      // ---- async reset mid-cycle clears r5 ----
      drive(0, 32'h0, 32'h12345678, 4'hF, 5'd5, 5'd5, 5'd5);
      drive(0, 32'h0, 32'h0, 4'h0, 5'd0, 5'd5, 5'd5);
      @(negedge Clk);
      check("r5_before_rst", Rs_data, 32'h12345678);
      #1 Reset = 1'b1;
      #1;
      check("r5_async_rst", Rs_data, 32'h0);
      check("rst_valid", {31'h0, WB_fwd_valid}, 32'h0);
      check("rst_fwd", WB_fwd_data, 32'h0);
      // write attempted on an edge with Reset high must be dropped
      WBData = 32'h0BADF00D; Rd_Write_Byte_en = 4'hF; Rd = 5'd6; Rs_addr = 5'd6;
      @(posedge Clk);
      #2 Reset = 1'b0; Rd_Write_Byte_en = 4'h0;
      @(negedge Clk);
      check("no_write_in_rst", Rs_data, 32'h0);

      // ---- full-word bypass and store ----
      drive(0, 32'h0, 32'hDEADBEEF, 4'hF, 5'd7, 5'd7, 5'd1);
      @(negedge Clk);
      check("r7_bypass", Rs_data, 32'hDEADBEEF);
      check("r7_valid", {31'h0, WB_fwd_valid}, 32'h1);
      drive(0, 32'h0, 32'h0, 4'h0, 5'd0, 5'd7, 5'd7);
      @(negedge Clk);
      check("r7_stored", Rs_data, 32'hDEADBEEF);

      // ---- halfword load merge ----
      drive(0, 32'h0, 32'hAABBCCDD, 4'hF, 5'd3, 5'd0, 5'd0);
      drive(1, 32'h11223344, 32'h0, 4'b0011, 5'd3, 5'd3, 5'd2);
      @(negedge Clk);
      check("r3_bypass", Rs_data, 32'hAABB3344);
      check("r3_fwd", WB_fwd_data, 32'h11223344);
      drive(0, 32'h0, 32'h0, 4'h0, 5'd0, 5'd2, 5'd3);
      @(negedge Clk);
      check("r3_stored", Rt_data, 32'hAABB3344);

      // ---- writes to r0 discarded ----
      drive(0, 32'h0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd0, 5'd0);
      @(negedge Clk);
      check("r0_bypass", Rs_data, 32'h0);
      check("r0_valid", {31'h0, WB_fwd_valid}, 32'h0);
      check("r0_fwd", WB_fwd_data, 32'hFFFFFFFF);
      drive(0, 32'h0, 32'h0, 4'h0, 5'd0, 5'd0, 5'd0);
      @(negedge Clk);
      check("r0_stored", Rs_data, 32'h0);

      // ---- both ports on Rd, top byte only ----
      drive(0, 32'h0, 32'h00000001, 4'hF, 5'd9, 5'd0, 5'd0);
      drive(0, 32'h0, 32'h5A000000, 4'b1000, 5'd9, 5'd9, 5'd9);
      @(negedge Clk);
      check("r9_rs", Rs_data, 32'h5A000001);
      check("r9_rt", Rt_data, 32'h5A000001);

      // ---- zero enables are a no-op ----
      drive(0, 32'h0, 32'h44444444, 4'hF, 5'd4, 5'd0, 5'd0);
      drive(0, 32'h0, 32'hCAFEF00D, 4'h0, 5'd4, 5'd4, 5'd4);
      @(negedge Clk);
      check("r4_nobypass", Rs_data, 32'h44444444);
      check("r4_valid", {31'h0, WB_fwd_valid}, 32'h0);
      drive(0, 32'h0, 32'h0, 4'h0, 5'd0, 5'd4, 5'd0);
      @(negedge Clk);
      check("r4_unchanged", Rs_data, 32'h44444444);

      // ---- randomized traffic ----
      for (int n = 0; n < 600; n++) begin
         logic [4:0] rd;
         logic [4:0] rs;
         logic [4:0] rt;
         rd = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
         rs = ($urandom_range(3) == 0) ? rd : 5'($urandom);
         rt = ($urandom_range(3) == 0) ? rd : 5'($urandom);
         drive(1'($urandom), $urandom, $urandom, 4'($urandom), rd, rs, rt);
         if ($urandom_range(79) == 0) begin
            @(negedge Clk);
            #1 Reset = 1'b1;
            #2 Reset = 1'b0;
         end
      end

      drive(0, 32'h0, 32'h0, 4'h0, 5'd0, 5'd0, 5'd0);
      @(negedge Clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_wb_reg_file
`default_nettype wire
